// File: rtl/sonic_tx_st_arbiter.sv
// sonic_tx_st_arbiter
//
// Packet-level round-robin arbiter that shares the 128-bit Avalon-ST PCIe TX
// port (tx_st_*) between two application sources:
//   A - DMA write / descriptor engine
//   B - completion / MSI path
// One source is granted per packet and the grant is held from sop to eop.
// Accepted beats pass through a single output register before reaching the
// hard-IP TX port.
//
// Handshake: every interface uses strict valid/ready semantics. A beat moves
// only in a cycle where valid && ready are both high. A source must hold its
// beat stable while valid && !ready. Ready never depends on the same
// interface's valid.
//
// Ports:
//   clk_in, rstn                 clock, asynchronous active-low reset
//   a_data/a_sop/a_eop/a_empty   source A beat and framing (empty=1: upper 64 bits unused)
//   a_valid / a_ready            source A handshake
//   b_* / b_ready                source B, same as A
//   tx_st_data/sop/eop/empty     registered beat towards the core
//   tx_st_err                    constant 0
//   tx_st_valid / tx_st_ready    core-side handshake
//   arb_owner                    one-hot grant (bit0=A, bit1=B, 00 = idle); exposes the FSM state
//   wdog_err                     sticky mid-packet stall timeout
//
// Optional feature: define SONIC_TX_ARB_WATCHDOG_EN to build the mid-packet
// stall watchdog (TIMEOUT cycles). Without it wdog_err is 0 and a granted
// packet may stall forever.

module sonic_tx_st_arbiter #(
    parameter int DATA_W  = 128,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk_in,
    input  logic              rstn,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_sop,
    input  logic              a_eop,
    input  logic              a_empty,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_sop,
    input  logic              b_eop,
    input  logic              b_empty,
    input  logic              b_valid,
    output logic              b_ready,
    output logic [DATA_W-1:0] tx_st_data,
    output logic              tx_st_sop,
    output logic              tx_st_eop,
    output logic              tx_st_empty,
    output logic              tx_st_err,
    output logic              tx_st_valid,
    input  logic              tx_st_ready,
    output logic [1:0]        arb_owner,
    output logic              wdog_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PKT_A = 2'd1,
        ST_PKT_B = 2'd2
    } state_t;

    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                sop_q, sop_d;
    logic                eop_q, eop_d;
    logic                empty_q, empty_d;
    logic                valid_q, valid_d;

    logic                reg_free;
    logic                load;
    logic                a_elig;
    logic                b_elig;

`ifdef SONIC_TX_ARB_WATCHDOG_EN
    localparam int             CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                wdog_q, wdog_d;
    logic                gnt_valid;
`endif

    // The output register can take a beat when it is empty or draining now.
    assign reg_free = !valid_q || tx_st_ready;
    assign a_elig   = a_valid && a_sop;
    assign b_elig   = b_valid && b_sop;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        a_ready      = 1'b0;
        b_ready      = 1'b0;
        load         = 1'b0;
        data_d       = data_q;
        sop_d        = sop_q;
        eop_d        = eop_q;
        empty_d      = empty_q;
        valid_d      = valid_q;

        case (state_q)
            ST_IDLE: begin
                // On a tie the source that did not own the last packet wins.
                if (a_elig && (!b_elig || last_grant_q == GRANT_B)) begin
                    state_d = ST_PKT_A;
                end else if (b_elig) begin
                    state_d = ST_PKT_B;
                end
            end
            ST_PKT_A: begin
                a_ready = reg_free;
                if (a_valid && reg_free) begin
                    load    = 1'b1;
                    data_d  = a_data;
                    sop_d   = a_sop;
                    eop_d   = a_eop;
                    empty_d = a_empty;
                    if (a_eop) begin
                        state_d      = ST_IDLE;
                        last_grant_d = GRANT_A;
                    end
                end
            end
            ST_PKT_B: begin
                b_ready = reg_free;
                if (b_valid && reg_free) begin
                    load    = 1'b1;
                    data_d  = b_data;
                    sop_d   = b_sop;
                    eop_d   = b_eop;
                    empty_d = b_empty;
                    if (b_eop) begin
                        state_d      = ST_IDLE;
                        last_grant_d = GRANT_B;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            valid_d = 1'b1;
        end else if (valid_q && tx_st_ready) begin
            valid_d = 1'b0;
        end

`ifdef SONIC_TX_ARB_WATCHDOG_EN
        cnt_d     = cnt_q;
        wdog_d    = wdog_q;
        gnt_valid = (state_q == ST_PKT_A) ? a_valid : b_valid;
        if (state_q == ST_IDLE || load) begin
            cnt_d = '0;
        end else if (!gnt_valid) begin
            // The cycle that would bring the count to TIMEOUT aborts the
            // packet; nothing is emitted, the output register drains alone.
            if (cnt_q == CNT_LAST) begin
                wdog_d  = 1'b1;
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_B;
            data_q       <= '0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            empty_q      <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            data_q       <= data_d;
            sop_q        <= sop_d;
            eop_q        <= eop_d;
            empty_q      <= empty_d;
            valid_q      <= valid_d;
        end
    end

`ifdef SONIC_TX_ARB_WATCHDOG_EN
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            cnt_q  <= '0;
            wdog_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wdog_q <= wdog_d;
        end
    end

    assign wdog_err = wdog_q;
`else
    // TIMEOUT is non-negative, so this is a constant 0; referencing it keeps
    // the parameter in use when the watchdog is not built.
    assign wdog_err = (TIMEOUT < 0);
`endif

    assign tx_st_data  = data_q;
    assign tx_st_sop   = sop_q;
    assign tx_st_eop   = eop_q;
    assign tx_st_empty = empty_q;
    assign tx_st_valid = valid_q;
    assign tx_st_err   = 1'b0;
    assign arb_owner   = {state_q == ST_PKT_B, state_q == ST_PKT_A};

endmodule

// File: tb/tb_sonic_tx_st_arbiter.sv
// Testbench for sonic_tx_st_arbiter: table of per-cycle vectors with
// hand-computed expectations, followed by a hand-written stall sequence.
// Each vector is applied 1 time unit after a rising edge and checked 1 time
// unit later, so registered outputs show the result of the previous edge and
// ready shows the combinational response to the current state.

module tb_sonic_tx_st_arbiter;

    localparam int DATA_W = 128;

    logic              clk;
    logic              rstn;
    logic [DATA_W-1:0] a_data, b_data;
    logic              a_sop, a_eop, a_empty, a_valid, a_ready;
    logic              b_sop, b_eop, b_empty, b_valid, b_ready;
    logic [DATA_W-1:0] tx_st_data;
    logic              tx_st_sop, tx_st_eop, tx_st_empty, tx_st_err, tx_st_valid;
    logic              tx_st_ready;
    logic [1:0]        arb_owner;
    logic              wdog_err;

    sonic_tx_st_arbiter #(
        .DATA_W (DATA_W),
        .TIMEOUT(16)
    ) dut (
        .clk_in     (clk),
        .rstn       (rstn),
        .a_data     (a_data),
        .a_sop      (a_sop),
        .a_eop      (a_eop),
        .a_empty    (a_empty),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .b_data     (b_data),
        .b_sop      (b_sop),
        .b_eop      (b_eop),
        .b_empty    (b_empty),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .tx_st_data (tx_st_data),
        .tx_st_sop  (tx_st_sop),
        .tx_st_eop  (tx_st_eop),
        .tx_st_empty(tx_st_empty),
        .tx_st_err  (tx_st_err),
        .tx_st_valid(tx_st_valid),
        .tx_st_ready(tx_st_ready),
        .arb_owner  (arb_owner),
        .wdog_err   (wdog_err)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vectors ----------------
    typedef struct {
        logic        rst_n;
        logic        av, as_, ae, am;
        logic [15:0] ad;
        logic        bv, bs, be, bm;
        logic [15:0] bd;
        logic        rdy;
        logic        x_ar, x_br;
        logic [1:0]  x_own;
        logic        x_v, x_sop, x_eop, x_emp;
        logic [15:0] x_d;
    } vec_t;

    vec_t vecs[$];
    vec_t cur;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic add(input logic rst, input logic av, input logic as_, input logic ae,
                       input logic am, input logic [15:0] ad,
                       input logic bv, input logic bs, input logic be, input logic bm,
                       input logic [15:0] bd, input logic rdy,
                       input logic x_ar, input logic x_br, input logic [1:0] x_own,
                       input logic x_v, input logic x_sop, input logic x_eop,
                       input logic x_emp, input logic [15:0] x_d);
        vec_t t;
        t.rst_n = rst;
        t.av = av; t.as_ = as_; t.ae = ae; t.am = am; t.ad = ad;
        t.bv = bv; t.bs = bs; t.be = be; t.bm = bm; t.bd = bd;
        t.rdy = rdy;
        t.x_ar = x_ar; t.x_br = x_br; t.x_own = x_own;
        t.x_v = x_v; t.x_sop = x_sop; t.x_eop = x_eop; t.x_emp = x_emp; t.x_d = x_d;
        vecs.push_back(t);
    endtask

    function automatic logic [DATA_W-1:0] expand(input logic [15:0] tag);
        return {8{tag}};
    endfunction

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        rstn        = v.rst_n;
        a_valid     = v.av;
        a_sop       = v.as_;
        a_eop       = v.ae;
        a_empty     = v.am;
        a_data      = expand(v.ad);
        b_valid     = v.bv;
        b_sop       = v.bs;
        b_eop       = v.be;
        b_empty     = v.bm;
        b_data      = expand(v.bd);
        tx_st_ready = v.rdy;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- test ----------------
    initial begin
        rstn        = 1'b0;
        a_valid     = 1'b0; a_sop = 1'b0; a_eop = 1'b0; a_empty = 1'b0; a_data = '0;
        b_valid     = 1'b0; b_sop = 1'b0; b_eop = 1'b0; b_empty = 1'b0; b_data = '0;
        tx_st_ready = 1'b1;

        //  rst  av as ae am ad       bv bs be bm bd       rdy  ar br own    v sop eop emp data
        // reset
        add(0,   0, 0, 0, 0, 16'h0,   0, 0, 0, 0, 16'h0,   1,   0, 0, 2'b00, 0, 0, 0, 0, 16'h0);
        add(0,   0, 0, 0, 0, 16'h0,   0, 0, 0, 0, 16'h0,   1,   0, 0, 2'b00, 0, 0, 0, 0, 16'h0);
        // A: 3-beat packet, last beat has empty=1
        add(1,   1, 1, 0, 0, 16'hA101, 0, 0, 0, 0, 16'h0,  1,   0, 0, 2'b00, 0, 0, 0, 0, 16'h0);
        add(1,   1, 1, 0, 0, 16'hA101, 0, 0, 0, 0, 16'h0,  1,   1, 0, 2'b01, 0, 0, 0, 0, 16'h0);
        add(1,   1, 0, 0, 0, 16'hA102, 0, 0, 0, 0, 16'h0,  1,   1, 0, 2'b01, 1, 1, 0, 0, 16'hA101);
        add(1,   1, 0, 1, 1, 16'hA103, 0, 0, 0, 0, 16'h0,  1,   1, 0, 2'b01, 1, 0, 0, 0, 16'hA102);
        add(1,   0, 0, 0, 0, 16'h0,   0, 0, 0, 0, 16'h0,   1,   0, 0, 2'b00, 1, 0, 1, 1, 16'hA103);
        add(1,   0, 0, 0, 0, 16'h0,   0, 0, 0, 0, 16'h0,   1,   0, 0, 2'b00, 0, 0, 0, 0, 16'h0);
        // reset so the tie sequence starts from last_grant=B
        add(0,   0, 0, 0, 0, 16'h0,   0, 0, 0, 0, 16'h0,   1,   0, 0, 2'b00, 0, 0, 0, 0, 16'h0);
        // A and B tie, 2-beat packets: grants A, B, A, B
        add(1,   1, 1, 0, 0, 16'hA201, 1, 1, 0, 0, 16'hB201, 1,  0, 0, 2'b00, 0, 0, 0, 0, 16'h0);
        add(1,   1, 1, 0, 0, 16'hA201, 1, 1, 0, 0, 16'hB201, 1,  1, 0, 2'b01, 0, 0, 0, 0, 16'h0);
        add(1,   1, 0, 1, 0, 16'hA202, 1, 1, 0, 0, 16'hB201, 1,  1, 0, 2'b01, 1, 1, 0, 0, 16'hA201);
        add(1,   1, 1, 0, 0, 16'hA203, 1, 1, 0, 0, 16'hB201, 1,  0, 0, 2'b00, 1, 0, 1, 0, 16'hA202);
        add(1,   1, 1, 0, 0, 16'hA203, 1, 1, 0, 0, 16'hB201, 1,  0, 1, 2'b10, 0, 0, 0, 0, 16'h0);
        add(1,   1, 1, 0, 0, 16'hA203, 1, 0, 1, 1, 16'hB202, 1,  0, 1, 2'b10, 1, 1, 0, 0, 16'hB201);
        add(1,   1, 1, 0, 0, 16'hA203, 1, 1, 0, 0, 16'hB203, 1,  0, 0, 2'b00, 1, 0, 1, 1, 16'hB202);
        add(1,   1, 1, 0, 0, 16'hA203, 1, 1, 0, 0, 16'hB203, 1,  1, 0, 2'b01, 0, 0, 0, 0, 16'h0);
        add(1,   1, 0, 1, 0, 16'hA204, 1, 1, 0, 0, 16'hB203, 1,  1, 0, 2'b01, 1, 1, 0, 0, 16'hA203);
        add(1,   0, 0, 0, 0, 16'h0,   1, 1, 0, 0, 16'hB203, 1,   0, 0, 2'b00, 1, 0, 1, 0, 16'hA204);
        add(1,   0, 0, 0, 0, 16'h0,   1, 1, 0, 0, 16'hB203, 1,   0, 1, 2'b10, 0, 0, 0, 0, 16'h0);
        add(1,   0, 0, 0, 0, 16'h0,   1, 0, 1, 0, 16'hB204, 1,   0, 1, 2'b10, 1, 1, 0, 0, 16'hB203);
        add(1,   0, 0, 0, 0, 16'h0,   0, 0, 0, 0, 16'h0,   1,   0, 0, 2'b00, 1, 0, 1, 0, 16'hB204);
        // A 4-beat packet, tx_st_ready=0 for 5 cycles while beat 2 sits in the register
        add(1,   1, 1, 0, 0, 16'hC301, 0, 0, 0, 0, 16'h0,  1,   0, 0, 2'b00, 0, 0, 0, 0, 16'h0);
        add(1,   1, 1, 0, 0, 16'hC301, 0, 0, 0, 0, 16'h0,  1,   1, 0, 2'b01, 0, 0, 0, 0, 16'h0);
        add(1,   1, 0, 0, 0, 16'hC302, 0, 0, 0, 0, 16'h0,  1,   1, 0, 2'b01, 1, 1, 0, 0, 16'hC301);
        for (int k = 0; k < 5; k++) begin
            add(1, 1, 0, 0, 0, 16'hC303, 0, 0, 0, 0, 16'h0, 0,   0, 0, 2'b01, 1, 0, 0, 0, 16'hC302);
        end
        add(1,   1, 0, 0, 0, 16'hC303, 0, 0, 0, 0, 16'h0,  1,   1, 0, 2'b01, 1, 0, 0, 0, 16'hC302);
        add(1,   1, 0, 1, 1, 16'hC304, 0, 0, 0, 0, 16'h0,  1,   1, 0, 2'b01, 1, 0, 0, 0, 16'hC303);
        add(1,   0, 0, 0, 0, 16'h0,   0, 0, 0, 0, 16'h0,   1,   0, 0, 2'b00, 1, 0, 1, 1, 16'hC304);
        // B single-beat packets back to back: owner toggles 10/00
        add(1,   0, 0, 0, 0, 16'h0,   1, 1, 1, 0, 16'hD401, 1,  0, 0, 2'b00, 0, 0, 0, 0, 16'h0);
        add(1,   0, 0, 0, 0, 16'h0,   1, 1, 1, 0, 16'hD401, 1,  0, 1, 2'b10, 0, 0, 0, 0, 16'h0);
        add(1,   0, 0, 0, 0, 16'h0,   1, 1, 1, 1, 16'hD402, 1,  0, 0, 2'b00, 1, 1, 1, 0, 16'hD401);
        add(1,   0, 0, 0, 0, 16'h0,   1, 1, 1, 1, 16'hD402, 1,  0, 1, 2'b10, 0, 0, 0, 0, 16'h0);
        add(1,   0, 0, 0, 0, 16'h0,   1, 1, 1, 0, 16'hD403, 1,  0, 0, 2'b00, 1, 1, 1, 1, 16'hD402);
        add(1,   0, 0, 0, 0, 16'h0,   1, 1, 1, 0, 16'hD403, 1,  0, 1, 2'b10, 0, 0, 0, 0, 16'h0);
        add(1,   0, 0, 0, 0, 16'h0,   0, 0, 0, 0, 16'h0,   1,   0, 0, 2'b00, 1, 1, 1, 0, 16'hD403);
        // reset during beat 2 of a B packet, then A wins the first tie
        add(1,   0, 0, 0, 0, 16'h0,   1, 1, 0, 0, 16'hE501, 1,  0, 0, 2'b00, 0, 0, 0, 0, 16'h0);
        add(1,   0, 0, 0, 0, 16'h0,   1, 1, 0, 0, 16'hE501, 1,  0, 1, 2'b10, 0, 0, 0, 0, 16'h0);
        add(0,   0, 0, 0, 0, 16'h0,   1, 0, 0, 0, 16'hE502, 1,  0, 0, 2'b00, 0, 0, 0, 0, 16'h0);
        add(1,   1, 1, 1, 0, 16'hF501, 1, 1, 0, 0, 16'hE501, 1,  0, 0, 2'b00, 0, 0, 0, 0, 16'h0);
        add(1,   1, 1, 1, 0, 16'hF501, 1, 1, 0, 0, 16'hE501, 1,  1, 0, 2'b01, 0, 0, 0, 0, 16'h0);
        add(1,   0, 0, 0, 0, 16'h0,   1, 1, 0, 0, 16'hE501, 1,  0, 0, 2'b00, 1, 1, 1, 0, 16'hF501);
        add(1,   0, 0, 0, 0, 16'h0,   1, 1, 0, 0, 16'hE501, 1,  0, 1, 2'b10, 0, 0, 0, 0, 16'h0);
        add(1,   0, 0, 0, 0, 16'h0,   1, 0, 1, 0, 16'hE502, 1,  0, 1, 2'b10, 1, 1, 0, 0, 16'hE501);
        add(1,   0, 0, 0, 0, 16'h0,   0, 0, 0, 0, 16'h0,   1,   0, 0, 2'b00, 1, 0, 1, 0, 16'hE502);

        // Reset values of the registered data path.
        repeat (2) @(posedge clk);
        #1;
        chk("reset tx_st_data", tx_st_data, '0);
        chk("reset tx_st_sop", {127'd0, tx_st_sop}, '0);
        chk("reset wdog_err", {127'd0, wdog_err}, '0);

        for (int i = 0; i < vecs.size(); i++) begin
            cur = vecs[i];
            tick();
            apply(cur);
            #1;
            chk($sformatf("row%0d a_ready", i), {127'd0, a_ready}, {127'd0, cur.x_ar});
            chk($sformatf("row%0d b_ready", i), {127'd0, b_ready}, {127'd0, cur.x_br});
            chk($sformatf("row%0d arb_owner", i), {126'd0, arb_owner}, {126'd0, cur.x_own});
            chk($sformatf("row%0d tx_st_valid", i), {127'd0, tx_st_valid}, {127'd0, cur.x_v});
            chk($sformatf("row%0d tx_st_err", i), {127'd0, tx_st_err}, '0);
            chk($sformatf("row%0d wdog_err", i), {127'd0, wdog_err}, '0);
            if (cur.x_v) begin
                chk($sformatf("row%0d tx_st_sop", i), {127'd0, tx_st_sop}, {127'd0, cur.x_sop});
                chk($sformatf("row%0d tx_st_eop", i), {127'd0, tx_st_eop}, {127'd0, cur.x_eop});
                chk($sformatf("row%0d tx_st_empty", i), {127'd0, tx_st_empty}, {127'd0, cur.x_emp});
                chk($sformatf("row%0d tx_st_data", i), tx_st_data, expand(cur.x_d));
            end
        end

        // A opens a packet with sop, then drops valid for 16 cycles.
        tick();
        a_valid = 1'b1; a_sop = 1'b1; a_eop = 1'b0; a_empty = 1'b0; a_data = expand(16'h7701);
        b_valid = 1'b0; tx_st_ready = 1'b1;
        #1;
        chk("stall idle owner", {126'd0, arb_owner}, {126'd0, 2'b00});
        tick();
        #1;
        chk("stall grant owner", {126'd0, arb_owner}, {126'd0, 2'b01});
        chk("stall grant a_ready", {127'd0, a_ready}, {127'd0, 1'b1});
        tick();
        a_valid = 1'b0;
        #1;
        chk("stall sop valid", {127'd0, tx_st_valid}, {127'd0, 1'b1});
        chk("stall sop data", tx_st_data, expand(16'h7701));
        repeat (16) tick();
        #1;
        chk("stall tx drained", {127'd0, tx_st_valid}, '0);
`ifdef SONIC_TX_ARB_WATCHDOG_EN
        chk("stall wdog owner", {126'd0, arb_owner}, {126'd0, 2'b00});
        chk("stall wdog_err", {127'd0, wdog_err}, {127'd0, 1'b1});
`else
        chk("stall owner held", {126'd0, arb_owner}, {126'd0, 2'b01});
        chk("stall wdog_err", {127'd0, wdog_err}, '0);
        // Finish the stalled packet so B can follow.
        a_valid = 1'b1; a_sop = 1'b0; a_eop = 1'b1; a_data = expand(16'h7702);
        tick();
        a_valid = 1'b0;
        #1;
        chk("stall eop valid", {127'd0, tx_st_valid}, {127'd0, 1'b1});
        chk("stall eop flag", {127'd0, tx_st_eop}, {127'd0, 1'b1});
        chk("stall eop data", tx_st_data, expand(16'h7702));
`endif
        // A following B single-beat packet is granted and completes.
        b_valid = 1'b1; b_sop = 1'b1; b_eop = 1'b1; b_empty = 1'b0; b_data = expand(16'h8801);
        tick();
        #1;
        chk("post owner", {126'd0, arb_owner}, {126'd0, 2'b10});
        chk("post b_ready", {127'd0, b_ready}, {127'd0, 1'b1});
        tick();
        b_valid = 1'b0;
        #1;
        chk("post valid", {127'd0, tx_st_valid}, {127'd0, 1'b1});
        chk("post data", tx_st_data, expand(16'h8801));
        chk("post framing", {126'd0, tx_st_sop, tx_st_eop}, {126'd0, 2'b11});
        chk("post owner idle", {126'd0, arb_owner}, {126'd0, 2'b00});
`ifdef SONIC_TX_ARB_WATCHDOG_EN
        chk("post wdog sticky", {127'd0, wdog_err}, {127'd0, 1'b1});
`else
        chk("post wdog_err", {127'd0, wdog_err}, '0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
